cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview: 32-bit single-bus CPU datapath: 16 general registers R0–R15 plus PC, IR, HI, LO, Y, 64-bit Z, MAR, MDR, in/out port registers and an ALU, all joined by one 32-bit internal bus. A one-hot set of "out" strobes picks the bus source. A set of "in" strobes loads registers on the rising clock edge. An external control sequencer, or a bench acting as one, drives every strobe each cycle.

Parameters:
WIDTH, 32, datapath/bus width (ALU result is 2*WIDTH)

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  asynchronous active-low reset
R0in..R15in  input  1 each  load Rn from bus
PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Cin, Yin  input  1 each  load enables (OutPort loads out-port reg; Cin reserved, no effect)
R0out..R15out  input  1 each  drive Rn onto bus
PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout  input  1 each  bus source selects (InPort = in-port reg, Cout = sign-extended IR[18:0])
Read  input  1  MDR takes Mdatain instead of bus
Mdatain  input  32  memory read data
IncPC  input  1  ALU computes bus+1, overrides OP
OP  input  5  ALU opcode
InPort_data  input  32  external input-port value, sampled every cycle into in-port reg
OutPort_data  output  32  out-port register contents
BusMuxOut  output  32  current bus value (observation)
Ports keep exactly the order above; the last three trail the strobe list.

Behaviour:
- Reset (Clear=0, async): every register (R0–R15, PC, IR, HI, LO, Y, ZHigh, ZLow, MAR, MDR, in-port, out-port) = 0; OutPort_data=0.
- Bus: combinational mux. Priority if several selects are high: R0..R15, PC, HI, LO, ZHigh, ZLow, MDR, InPort, C. With no select high the bus is 0.
- Registers: all edge-triggered on rising Clock. A register loads only when its enable is high, otherwise it holds. Several enables in one cycle are allowed; each target takes the same bus value.
- MDR: with MDRin=1 it loads Mdatain if Read=1, else the bus. Read without MDRin has no effect.
- ALU: combinational. A=Y, B=bus, 64-bit result. ZLowin loads result[31:0]; ZHighin loads result[63:32]. Each is independent.
- IncPC=1: result = {32'b0, B+1}, regardless of OP.
- OP encoding:
  00011 ADD
  00100 SUB
  00101 AND
  00110 OR
  00111 SHRA (arithmetic right)
  01000 SHR (logical right)
  01001 SHL
  01010 ROR
  01011 ROL
  01111 MUL (signed 64-bit)
  10000 DIV (signed: low=quotient, high=remainder)
  10001 NEG (-B)
  10010 NOT (~B)
  any other code: result 0
- Shift/rotate amount = B[4:0]; shifts operate on A. High half = 0 except MUL/DIV. ADD/SUB wrap modulo 2^32.
- DIV by zero: low=0, high=A.
- C value = {{13{IR[18]}}, IR[18:0]}.
- Latency: a value moves from one register to another in one cycle via the bus. An ALU op needs Yin in cycle n, then OP+ZLowin in cycle n+1, then ZLowout+Rdin in cycle n+2.
- Reset mid-operation wins immediately; strobes are ignored while Clear=0.

Test Plan:
- Reset: pulse Clear low -> every register 0, BusMuxOut 0 with no selects.
- Load: Clear=1, Mdatain=0x12, Read+MDRin one edge, then MDRout+R3in -> R3=0x12. Repeat 0x14->R5, 0x18->R1.
- PC increment: PC=0. Cycle 1: PCout+MARin+IncPC+ZLowin -> MAR=0, ZLow=1. Cycle 2: ZLowout+PCin, plus Read+MDRin with Mdatain=0x389A8000 -> PC=1, MDR=0x389A8000. Cycle 3: MDRout+IRin -> IR=0x389A8000.
- SHR: cycle 1: R3out+Yin (Y=0x12). Cycle 2: R5out+OP=01000+ZLowin -> ZLow=0x12>>20=0. Repeat with R5=2 -> ZLow=0x4. Then ZLowout+R1in -> R1=0x4.
- MUL/DIV: Y=-6, B=4. MUL -> ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFE8. DIV with Y=13, B=4 -> ZLow=3, ZHigh=1. B=0 -> ZLow=0, ZHigh=13.
- C sign-extend/ports: IR=0x0007FFFF with Cout -> bus 0xFFFFFFFF. InPort_data=0xA5 with InPort+R7in -> R7=0xA5. R7out+OutPort -> OutPort_data=0xA5.

Source files
------------

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: general registers, special registers, ALU and
// in/out ports joined by one internal bus whose source is picked by "out" strobes.
module cpu_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             R0in,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             ZHighin,
  input  logic             ZLowin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             OutPort,
  input  logic             Cin,
  input  logic             Yin,
  input  logic             R0out,
  input  logic             R1out,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             R8out,
  input  logic             R9out,
  input  logic             R10out,
  input  logic             R11out,
  input  logic             R12out,
  input  logic             R13out,
  input  logic             R14out,
  input  logic             R15out,
  input  logic             PCout,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHighout,
  input  logic             ZLowout,
  input  logic             MDRout,
  input  logic             InPort,
  input  logic             Cout,
  input  logic             Read,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             IncPC,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] InPort_data,
  output logic [WIDTH-1:0] OutPort_data,
  output logic [WIDTH-1:0] BusMuxOut
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHRA = 5'b00111,
    OP_SHR  = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [15:0]      rin, rout;
  logic [WIDTH-1:0] gpr_q [16];
  logic [WIDTH-1:0] pc_q, ir_q, hi_q, lo_q, y_q, zhi_q, zlo_q, mar_q, mdr_q;
  logic [WIDTH-1:0] inport_q, outport_q;
  logic [WIDTH-1:0] mdr_d, c_val, bus_mux;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0] quo, rem;
  logic [SHW-1:0]   sh;
  alu_op_e          op;
  logic             hit;
  logic             unused_sig;

  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  assign c_val = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};
  assign mdr_d = Read ? Mdatain : bus_mux;

  // Cin is a reserved strobe and MAR/IR upper bits have no internal reader.
  assign unused_sig = ^{Cin, mar_q, ir_q[WIDTH-1:19]};

  // Lowest-numbered general register wins, then the fixed special-source order.
  always_comb begin
    bus_mux = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!hit && rout[i[3:0]]) begin
        bus_mux = gpr_q[i[3:0]];
        hit     = 1'b1;
      end
    end
    if (!hit) begin
      if      (PCout)    bus_mux = pc_q;
      else if (HIout)    bus_mux = hi_q;
      else if (LOout)    bus_mux = lo_q;
      else if (ZHighout) bus_mux = zhi_q;
      else if (ZLowout)  bus_mux = zlo_q;
      else if (MDRout)   bus_mux = mdr_q;
      else if (InPort)   bus_mux = inport_q;
      else if (Cout)     bus_mux = c_val;
    end
  end

  assign op   = alu_op_e'(OP);
  assign sh   = bus_mux[SHW-1:0];
  assign prod = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus_mux[WIDTH-1]}}, bus_mux};

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    quo    = $signed(y_q) / $signed(bus_mux);
    rem    = $signed(y_q) % $signed(bus_mux);
    if (IncPC) begin
      res_lo = bus_mux + ONE;
    end else begin
      case (op)
        OP_ADD:  res_lo = y_q + bus_mux;
        OP_SUB:  res_lo = y_q - bus_mux;
        OP_AND:  res_lo = y_q & bus_mux;
        OP_OR:   res_lo = y_q | bus_mux;
        OP_SHRA: res_lo = $signed(y_q) >>> sh;
        OP_SHR:  res_lo = y_q >> sh;
        OP_SHL:  res_lo = y_q << sh;
        OP_ROR:  res_lo = (y_q >> sh) | (y_q << (WIDTH - sh));
        OP_ROL:  res_lo = (y_q << sh) | (y_q >> (WIDTH - sh));
        OP_MUL: begin
          res_lo = prod[WIDTH-1:0];
          res_hi = prod[2*WIDTH-1:WIDTH];
        end
        OP_DIV: begin
          if (bus_mux == '0) begin
            res_hi = y_q;
          end else begin
            res_lo = quo;
            res_hi = rem;
          end
        end
        OP_NEG:  res_lo = '0 - bus_mux;
        OP_NOT:  res_lo = ~bus_mux;
        default: res_lo = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int unsigned i = 0; i < 16; i++) gpr_q[i[3:0]] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (rin[i[3:0]]) gpr_q[i[3:0]] <= bus_mux;
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc_q      <= '0;
      ir_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      inport_q <= InPort_data;
      if (PCin)    pc_q      <= bus_mux;
      if (IRin)    ir_q      <= bus_mux;
      if (HIin)    hi_q      <= bus_mux;
      if (LOin)    lo_q      <= bus_mux;
      if (Yin)     y_q       <= bus_mux;
      if (MARin)   mar_q     <= bus_mux;
      if (OutPort) outport_q <= bus_mux;
      if (MDRin)   mdr_q     <= mdr_d;
      if (ZHighin) zhi_q     <= res_hi;
      if (ZLowin)  zlo_q     <= res_lo;
    end
  end

  assign BusMuxOut    = bus_mux;
  assign OutPort_data = outport_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: acts as the control sequencer and observes
// every register through the bus.
module tb_cpu_datapath;

  logic        Clock, Clear;
  logic [15:0] rin, rout;
  logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Cin, Yin;
  logic        PCout, HIout, LOout, ZHighout, ZLowout, MDRout, InPort, Cout, Read, IncPC;
  logic [4:0]  OP;
  logic [31:0] Mdatain, InPort_data, OutPort_data, BusMuxOut;

  int n_checks = 0;
  int n_errors = 0;

  cpu_datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear(Clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin),
    .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Cin(Cin), .Yin(Yin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .MDRout(MDRout), .InPort(InPort), .Cout(Cout), .Read(Read), .Mdatain(Mdatain),
    .IncPC(IncPC), .OP(OP), .InPort_data(InPort_data),
    .OutPort_data(OutPort_data), .BusMuxOut(BusMuxOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rin = '0; rout = '0;
    PCin = 0; IRin = 0; HIin = 0; LOin = 0; ZHighin = 0; ZLowin = 0;
    MARin = 0; MDRin = 0; OutPort = 0; Cin = 0; Yin = 0;
    PCout = 0; HIout = 0; LOout = 0; ZHighout = 0; ZLowout = 0;
    MDRout = 0; InPort = 0; Cout = 0; Read = 0; IncPC = 0; OP = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clr();
  endtask

  // Source codes: 0..15 Rn, 16 PC, 17 HI, 18 LO, 19 ZHigh, 20 ZLow, 21 MDR, 22 InPort, 23 C.
  task automatic set_src(input int s, input logic v);
    if (s < 16) rout[s[3:0]] = v;
    else case (s)
      16: PCout = v;
      17: HIout = v;
      18: LOout = v;
      19: ZHighout = v;
      20: ZLowout = v;
      21: MDRout = v;
      22: InPort = v;
      default: Cout = v;
    endcase
  endtask

  task automatic peek(input string tag, input int s, input logic [31:0] exp);
    set_src(s, 1'b1);
    #1;
    check_eq(tag, BusMuxOut, exp);
    set_src(s, 1'b0);
  endtask

  task automatic put_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic mdr_to_r(input logic [3:0] n);
    MDRout = 1; rin[n] = 1;
    tick();
  endtask

  task automatic run_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
    put_mdr(a);
    MDRout = 1; Yin = 1;
    tick();
    put_mdr(b);
    MDRout = 1; OP = op; ZLowin = 1; ZHighin = 1;
    tick();
    peek({tag, "_lo"}, 20, lo);
    peek({tag, "_hi"}, 19, hi);
  endtask

  initial begin
    clr();
    Mdatain = '0; InPort_data = '0;
    Clear = 1'b1;
    #1 Clear = 1'b0;
    #1;
    check_eq("rst_bus_idle", BusMuxOut, 32'h0);
    check_eq("rst_outport", OutPort_data, 32'h0);

    // Strobes across an edge while Clear is low must be ignored
    Mdatain = 32'hDEAD; Read = 1; MDRin = 1;
    tick();
    Clear = 1'b1;
    peek("rst_mdr_ignored", 21, 32'h0);

    // Load, then async reset mid-cycle clears everything
    put_mdr(32'h55);
    mdr_to_r(4'd3);
    peek("pre_r3", 3, 32'h55);
    MDRout = 1; OutPort = 1; PCin = 1; HIin = 1;
    tick();
    check_eq("pre_outport", OutPort_data, 32'h55);
    #2 Clear = 1'b0;
    #1 check_eq("async_outport", OutPort_data, 32'h0);
    Clear = 1'b1;
    for (int s = 0; s < 24; s++) peek($sformatf("rst_src%0d", s), s, 32'h0);

    // Memory loads into general registers
    put_mdr(32'h12); mdr_to_r(4'd3);
    put_mdr(32'h14); mdr_to_r(4'd5);
    put_mdr(32'h18); mdr_to_r(4'd1);
    peek("load_r3", 3, 32'h12);
    peek("load_r5", 5, 32'h14);
    peek("load_r1", 1, 32'h18);

    // Multiple destinations in one cycle; Read without MDRin holds MDR
    MDRout = 1; rin[8] = 1; rin[9] = 1;
    tick();
    peek("multi_r8", 8, 32'h18);
    peek("multi_r9", 9, 32'h18);
    Mdatain = 32'h99; Read = 1;
    tick();
    peek("read_no_mdrin", 21, 32'h18);

    // PC increment / instruction fetch; IncPC overrides OP
    PCout = 1; MARin = 1; IncPC = 1; ZLowin = 1; OP = 5'b00101;
    tick();
    peek("incpc_zlow", 20, 32'h1);
    ZLowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h389A8000;
    tick();
    peek("fetch_pc", 16, 32'h1);
    peek("fetch_mdr", 21, 32'h389A8000);
    MDRout = 1; IRin = 1;
    tick();
    peek("ir_c_pos", 23, 32'h00028000);

    // SHR sequence
    rout[3] = 1; Yin = 1;
    tick();
    rout[5] = 1; OP = 5'b01000; ZLowin = 1;
    tick();
    peek("shr20", 20, 32'h0);
    put_mdr(32'h2); mdr_to_r(4'd5);
    rout[5] = 1; OP = 5'b01000; ZLowin = 1;
    tick();
    peek("shr2", 20, 32'h4);
    ZLowout = 1; rin[1] = 1;
    tick();
    peek("shr_r1", 1, 32'h4);

    // ALU vectors: op, A, B, expected low, expected high
    run_alu("add_wrap", 5'b00011, 32'hFFFFFFFF, 32'h2,        32'h1,        32'h0);
    run_alu("sub_neg",  5'b00100, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0);
    run_alu("and",      5'b00101, 32'hF0F0FFFF, 32'h0FF00FF0, 32'h00F00FF0, 32'h0);
    run_alu("or",       5'b00110, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0);
    run_alu("shra",     5'b00111, 32'h80000010, 32'h4,        32'hF8000001, 32'h0);
    run_alu("shr31",    5'b01000, 32'h80000000, 32'd31,       32'h1,        32'h0);
    run_alu("shl31",    5'b01001, 32'h3,        32'd31,       32'h80000000, 32'h0);
    run_alu("shl_b33",  5'b01001, 32'h3,        32'd33,       32'h6,        32'h0);
    run_alu("ror1",     5'b01010, 32'h1,        32'h1,        32'h80000000, 32'h0);
    run_alu("ror0",     5'b01010, 32'h12345678, 32'h0,        32'h12345678, 32'h0);
    run_alu("rol4",     5'b01011, 32'h80000001, 32'h4,        32'h00000018, 32'h0);
    run_alu("mul_neg",  5'b01111, 32'hFFFFFFFA, 32'h4,        32'hFFFFFFE8, 32'hFFFFFFFF);
    run_alu("mul_big",  5'b01111, 32'h00010000, 32'h00010000, 32'h0,        32'h1);
    run_alu("div",      5'b10000, 32'd13,       32'd4,        32'd3,        32'd1);
    run_alu("div0",     5'b10000, 32'd13,       32'd0,        32'd0,        32'd13);
    run_alu("div_neg",  5'b10000, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_alu("neg",      5'b10001, 32'h0,        32'h5,        32'hFFFFFFFB, 32'h0);
    run_alu("not",      5'b10010, 32'h0,        32'h0000FFFF, 32'hFFFF0000, 32'h0);
    run_alu("bad_op",   5'b00000, 32'h5,        32'h5,        32'h0,        32'h0);

    // HI / LO registers
    put_mdr(32'h1111);
    MDRout = 1; HIin = 1;
    tick();
    put_mdr(32'h2222);
    MDRout = 1; LOin = 1;
    tick();
    peek("hi", 17, 32'h1111);
    peek("lo", 18, 32'h2222);

    // Bus priority with overlapping selects
    rout[3] = 1; PCout = 1; #1 check_eq("prio_r3_pc", BusMuxOut, 32'h12); clr();
    PCout = 1; ZLowout = 1; #1 check_eq("prio_pc_zlo", BusMuxOut, 32'h1); clr();
    MDRout = 1; Cout = 1; #1 check_eq("prio_mdr_c", BusMuxOut, 32'h2222); clr();

    // C sign extension and ports
    put_mdr(32'h0007FFFF);
    MDRout = 1; IRin = 1;
    tick();
    peek("c_signext", 23, 32'hFFFFFFFF);
    InPort_data = 32'hA5;
    tick();
    InPort = 1; rin[7] = 1;
    tick();
    peek("inport_r7", 7, 32'hA5);
    rout[7] = 1; OutPort = 1;
    tick();
    check_eq("outport", OutPort_data, 32'hA5);

    // Reset wins mid-operation
    rout[7] = 1; OutPort = 1;
    #2 Clear = 1'b0;
    #1 check_eq("midop_outport", OutPort_data, 32'h0);
    check_eq("midop_r7", BusMuxOut, 32'h0);
    Clear = 1'b1;
    clr();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
